mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0; 0 = round-robin between ports, 1 = data port always wins on conflict.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  instruction-fetch request, held high until if_ack is seen.
REQ-005 if_addr  input  16  fetch byte address.
REQ-006 if_ack  output  1  one-cycle pulse; fetch word complete.
REQ-007 if_rdata  output  16  fetched instruction word {byte[addr+1], byte[addr]}.
REQ-008 d_req  input  1  data request, held high until d_ack is seen.
REQ-009 d_we  input  1  1 = write, 0 = read.
REQ-010 d_addr  input  16  data byte address.
REQ-011 d_wdata  input  16  write word.
REQ-012 d_ack  output  1  one-cycle pulse; data access complete.
REQ-013 d_rdata  output  16  read word {byte[addr+1], byte[addr]}.
REQ-014 m_addr  output  16  byte address to single-port byte-wide unified memory.
REQ-015 m_wdata  output  8  byte write data.
REQ-016 m_we  output  1  byte write strobe.
REQ-017 m_rdata  input  8  byte read data, combinational from m_addr.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states: IDLE, LO, HI, RESP; one byte transfer per LO/HI cycle.
REQ-020 IDLE: if no req, stay; else grant one port at clock edge, latch its addr, we, wdata into internal registers, go to LO.
REQ-021 Only one port is granted at a time; requester inputs need be stable only in the grant cycle.
REQ-022 Conflict (both req in IDLE), FIXED_PRIO=0: grant the port not granted last; last_grant updates on every grant.
REQ-023 Conflict, FIXED_PRIO=1: data port granted; fetch waits.
REQ-024 LO: m_addr = latched addr; read captures m_rdata into low byte of the granted port's rdata register; write drives m_wdata = wdata[7:0], m_we = 1; next state HI.
REQ-025 HI: m_addr = latched addr + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000); read captures high byte; write drives wdata[15:8], m_we = 1; next state RESP.
REQ-026 RESP: granted port's ack = 1 for exactly this cycle; next state IDLE unconditionally.
REQ-027 Latency: grant edge to ack = 3 cycles; back-to-back accesses issue one word per 4 cycles.
REQ-028 A req still high in the IDLE cycle after RESP is treated as a new request.
REQ-029 m_we = 0 in IDLE and RESP, and in LO/HI for reads; m_addr = 0 and m_wdata = 0 when not in LO/HI.
REQ-030 if_rdata/d_rdata hold their last completed read value; a write never changes d_rdata; rdata is updated before the ack cycle.
REQ-031 Odd addresses are legal; no alignment check.

Reset
REQ-032 rst_n low forces IDLE, if_ack = d_ack = 0, m_we = 0, m_addr = m_wdata = 0, busy = 0, if_rdata = d_rdata = 0, last_grant = data (so fetch wins the first conflict), without waiting for clk.
REQ-033 Reset during LO/HI aborts the access with no ack; a low byte already written in LO remains written; the high byte is not written.

Verification
REQ-034 Fetch only: mem[0x0100]=0x34, mem[0x0101]=0x12, if_req with if_addr=0x0100 -> if_ack 3 cycles after grant, if_rdata = 0x1234, d_ack stays 0.
REQ-035 Write then read: d_we=1, d_addr=0x2000, d_wdata=0xBEEF -> m_we in 2 cycles, bytes 0xEF@0x2000, 0xBE@0x2001; then read 0x2000 -> d_rdata = 0xBEEF.
REQ-036 Wrap: read d_addr=0xFFFF with mem[0xFFFF]=0xCD, mem[0x0000]=0xAB -> m_addr 0xFFFF then 0x0000, d_rdata = 0xABCD.
REQ-037 Conflict, FIXED_PRIO=0: both req held continuously after reset -> grants alternate fetch, data, fetch, data; acks every 4 cycles.
REQ-038 Conflict, FIXED_PRIO=1: both req high -> data granted; fetch granted only after d_req drops.
REQ-039 Reset in HI of write 0x5566 to 0x3000 -> outputs zero immediately, no d_ack, mem[0x3000]=0x66, mem[0x3001] unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a byte-wide single-port memory.
// Each 16-bit access runs as IDLE -> LO byte -> HI byte -> RESP (ack).
module mem_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic [15:0] m_addr,
  output logic [7:0]  m_wdata,
  output logic        m_we,
  input  logic [7:0]  m_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        gnt_d_q, gnt_d_d;
  logic        last_d_q, last_d_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        pick_d;

  // On conflict the round-robin choice favours whoever was not granted last.
  always_comb begin
    if (if_req && d_req) begin
      pick_d = (FIXED_PRIO != 0) ? 1'b1 : ~last_d_q;
    end else begin
      pick_d = d_req;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d_d    = gnt_d_q;
    last_d_d   = last_d_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    lo_d       = lo_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    m_addr     = 16'h0000;
    m_wdata    = 8'h00;
    m_we       = 1'b0;
    if_ack     = 1'b0;
    d_ack      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          gnt_d_d  = pick_d;
          last_d_d = pick_d;
          addr_d   = pick_d ? d_addr : if_addr;
          we_d     = pick_d & d_we;
          wdata_d  = pick_d ? d_wdata : 16'h0000;
          state_d  = S_LO;
        end
      end
      S_LO: begin
        m_addr = addr_q;
        if (we_q) begin
          m_we    = 1'b1;
          m_wdata = wdata_q[7:0];
        end else begin
          lo_d = m_rdata;
        end
        state_d = S_HI;
      end
      S_HI: begin
        m_addr = addr_q + 16'd1;
        if (we_q) begin
          m_we    = 1'b1;
          m_wdata = wdata_q[15:8];
        end else if (gnt_d_q) begin
          d_rdata_d = {m_rdata, lo_q};
        end else begin
          if_rdata_d = {m_rdata, lo_q};
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if_ack  = ~gnt_d_q;
        d_ack   = gnt_d_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // last_d resets to 1 so fetch wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_d_q    <= 1'b0;
      last_d_q   <= 1'b1;
      addr_q     <= 16'h0000;
      we_q       <= 1'b0;
      wdata_q    <= 16'h0000;
      lo_q       <= 8'h00;
      if_rdata_q <= 16'h0000;
      d_rdata_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      gnt_d_q    <= gnt_d_d;
      last_d_q   <= last_d_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      lo_q       <= lo_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance with scoreboard on acks,
// plus a fixed-priority instance for the data-wins conflict case.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        if_req, d_req, d_we, if_ack, d_ack, m_we, busy;
  logic [15:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata, m_addr;
  logic [7:0]  m_wdata, m_rdata;
  logic [7:0]  mem [0:65535];

  logic        if_req1, d_req1, d_we1, if_ack1, d_ack1, m_we1, busy1;
  logic [15:0] if_addr1, d_addr1, d_wdata1, if_rdata1, d_rdata1, m_addr1;
  logic [7:0]  m_wdata1, m_rdata1;
  logic [7:0]  mem1 [0:65535];

  mem_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata),
    .busy(busy)
  );

  mem_arbiter #(.FIXED_PRIO(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req1), .if_addr(if_addr1), .if_ack(if_ack1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_ack(d_ack1), .d_rdata(d_rdata1),
    .m_addr(m_addr1), .m_wdata(m_wdata1), .m_we(m_we1), .m_rdata(m_rdata1),
    .busy(busy1)
  );

  assign m_rdata  = mem[m_addr];
  assign m_rdata1 = mem1[m_addr1];
  always @(posedge clk) if (m_we)  mem[m_addr]   <= m_wdata;
  always @(posedge clk) if (m_we1) mem1[m_addr1] <= m_wdata1;

  typedef struct {
    bit          port_d;
    logic [15:0] rdata;
  } exp_t;
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor for the round-robin instance.
  always @(negedge clk) begin
    if (rst_n && (if_ack || d_ack)) begin
      exp_t e;
      chk("ack_onehot", {31'd0, if_ack & d_ack}, 32'd0);
      if (sb.size() == 0) begin
        chk("sb_unexpected_ack", sb.size(), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_ack_port", {31'd0, d_ack}, {31'd0, e.port_d});
        chk("sb_rdata", e.port_d ? d_rdata : if_rdata, e.rdata);
      end
    end
  end

  task automatic wait_ack(input bit pd, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pd ? d_ack : if_ack) && n < 20);
  endtask

  initial begin
    int n, t;
    exp_t e;
    rst_n = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    if_req1 = 0; d_req1 = 0; d_we1 = 0; if_addr1 = 0; d_addr1 = 0; d_wdata1 = 0;
    mem[16'h0100] = 8'h34; mem[16'h0101] = 8'h12;
    mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
    mem[16'h3000] = 8'h11; mem[16'h3001] = 8'h77;
    mem1[16'h0100] = 8'h34; mem1[16'h0101] = 8'h12;
    mem1[16'h2000] = 8'hEF; mem1[16'h2001] = 8'hBE;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    chk("rst_mbus", {7'd0, m_we, m_addr, m_wdata}, 32'd0);
    chk("rst_rdata", {if_rdata, d_rdata}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // fetch only
    @(negedge clk);
    e.port_d = 1'b0; e.rdata = 16'h1234; sb.push_back(e);
    if_addr = 16'h0100; if_req = 1'b1;
    wait_ack(1'b0, n);
    if_req = 1'b0;
    chk("fetch_lat", n, 32'd3);
    chk("fetch_no_dack", {31'd0, d_ack}, 32'd0);

    // write 0xBEEF to 0x2000; inputs disturbed after grant to prove latching
    @(negedge clk);
    e.port_d = 1'b1; e.rdata = 16'h0000; sb.push_back(e);
    d_we = 1'b1; d_addr = 16'h2000; d_wdata = 16'hBEEF; d_req = 1'b1;
    @(negedge clk);
    chk("wr_lo", {7'd0, m_we, m_addr, m_wdata}, {7'd0, 1'b1, 16'h2000, 8'hEF});
    d_addr = 16'h5555; d_wdata = 16'h0000;
    @(negedge clk);
    chk("wr_hi", {7'd0, m_we, m_addr, m_wdata}, {7'd0, 1'b1, 16'h2001, 8'hBE});
    @(negedge clk);
    chk("wr_resp", {6'd0, busy, d_ack, m_we, m_addr, m_wdata}, {6'd0, 1'b1, 1'b1, 1'b0, 16'h0, 8'h0});
    d_req = 1'b0;
    chk("wr_mem", {16'd0, mem[16'h2001], mem[16'h2000]}, 32'h0000BEEF);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // read back
    e.port_d = 1'b1; e.rdata = 16'hBEEF; sb.push_back(e);
    d_we = 1'b0; d_addr = 16'h2000; d_req = 1'b1;
    wait_ack(1'b1, n);
    d_req = 1'b0;
    chk("rd_lat", n, 32'd3);

    // address wrap
    @(negedge clk);
    e.port_d = 1'b1; e.rdata = 16'hABCD; sb.push_back(e);
    d_addr = 16'hFFFF; d_req = 1'b1;
    @(negedge clk);
    chk("wrap_lo", {15'd0, m_we, m_addr}, {15'd0, 1'b0, 16'hFFFF});
    @(negedge clk);
    chk("wrap_hi", {15'd0, m_we, m_addr}, {15'd0, 1'b0, 16'h0000});
    @(negedge clk);
    chk("wrap_ack", {31'd0, d_ack}, 32'd1);
    d_req = 1'b0;

    // round-robin conflict straight out of reset: fetch first
    @(negedge clk);
    rst_n = 1'b0;
    if_addr = 16'h0100; d_addr = 16'h2000; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e.port_d = k[0]; e.rdata = k[0] ? 16'hBEEF : 16'h1234; sb.push_back(e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    for (int k = 0; k < 4; k++) begin
      do begin
        @(negedge clk);
        t++;
      end while (!(if_ack || d_ack) && t < 40);
      chk("rr_ack_time", t, 3 + 4 * k);
      chk("rr_ack_port", {30'd0, if_ack, d_ack}, k[0] ? 32'd1 : 32'd2);
    end
    if_req = 1'b0; d_req = 1'b0;

    // fixed priority: data wins while held, fetch only after d_req drops
    if_addr1 = 16'h0100; d_addr1 = 16'h2000;
    if_req1 = 1'b1; d_req1 = 1'b1;
    t = 0;
    for (int k = 0; k < 3; k++) begin
      do begin
        @(negedge clk);
        t++;
      end while (!(if_ack1 || d_ack1) && t < 40);
      chk("fp_ack_time", t, 3 + 4 * k);
      chk("fp_ack_port", {30'd0, if_ack1, d_ack1}, (k < 2) ? 32'd1 : 32'd2);
      if (k == 1) d_req1 = 1'b0;
    end
    if_req1 = 1'b0;
    chk("fp_rdata", {if_rdata1, d_rdata1}, 32'h1234BEEF);

    // reset during HI of a write aborts with only the low byte written
    @(negedge clk);
    d_we = 1'b1; d_addr = 16'h3000; d_wdata = 16'h5566; d_req = 1'b1;
    @(negedge clk);
    chk("abort_lo", {7'd0, m_we, m_addr, m_wdata}, {7'd0, 1'b1, 16'h3000, 8'h66});
    @(negedge clk);
    chk("abort_hi", {7'd0, m_we, m_addr, m_wdata}, {7'd0, 1'b1, 16'h3001, 8'h55});
    #1 rst_n = 1'b0;
    #1;
    chk("abort_outs", {6'd0, busy, d_ack, m_we, m_addr, m_wdata}, 32'd0);
    chk("abort_rdata", {if_rdata, d_rdata}, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("abort_mem", {16'd0, mem[16'h3001], mem[16'h3000]}, 32'h00007766);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("abort_no_ack", {30'd0, busy, d_ack}, 32'd0);

    chk("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
